uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_pkg.sv | 28 ++
 rtl/byte_fifo.sv | 79 +++++++
 rtl/uart_tx_mmio.sv | 157 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared FSM state encoding and register map for the UART TX block.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] REG_DATA    = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS  = 32'h0000_0004;
    localparam int unsigned REG_SEL_BIT = 2;

    function automatic logic [31:0] status_word(input logic ovf, input logic empty,
                                                input logic full, input logic busy);
        return {28'b0, ovf, empty, full, busy};
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
// Module  : byte_fifo
// Brief   : Power-of-two byte FIFO with occupancy count; read data is the head.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wr_data,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is still legal when the head leaves the same cycle.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ============================================================================
// Module  : uart_tx_mmio
// Brief   : Memory-mapped 8N1 UART transmitter with a byte FIFO and status reg.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        tx
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rdata_q, rdata_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rd_data;
    logic [CW-1:0] fifo_count;

    logic wr_hit, rd_hit, status_sel, at_cap, baud_end, busy;
    logic unused_bits;

    assign unused_bits = ^{mem_addr[31:REG_SEL_BIT+1], mem_addr[REG_SEL_BIT-1:0],
                           mem_wdata[31:8], mem_wmask[3:1]};

    assign status_sel = mem_addr[REG_SEL_BIT];
    assign wr_hit     = sel & ~status_sel & mem_wmask[0];
    assign rd_hit     = sel & mem_rstrb;
    assign busy       = (state_q != ST_IDLE);
    assign baud_end   = (baud_q == BAUD_LAST);
    assign at_cap     = (fifo_count == CW'(FIFO_DEPTH)) & ~fifo_pop;
    assign fifo_push  = wr_hit & ~at_cap;

    byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (mem_wdata[7:0]),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        rdata_d = rdata_q;
        if (rd_hit) begin
            rdata_d = status_sel ? status_word(ovf_q, fifo_empty, fifo_full, busy) : '0;
        end
        // A fresh overflow outranks the clear-on-read of the same cycle.
        ovf_d = (wr_hit & at_cap) | (ovf_q & ~(rd_hit & status_sel));
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    baud_d   = '0;
                    tx_d     = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign tx        = tx_q;
    assign mem_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// ============================================================================
// Module  : tb_uart_tx_mmio
// Brief   : Directed plus randomized bench with a frame-level reference model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        tx;

    int tests = 0;
    int fails = 0;

    // Reference model: pending bytes, start edge of the latest frame and its byte.
    logic [7:0]  mq[$];
    int          cyc    = 0;
    int          fstart = -1000;
    logic [7:0]  fbyte  = 8'h00;
    logic        m_ovf  = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    function automatic logic line_level(input int off, input logic [7:0] b);
        int slot;
        if (off < 0 || off >= 10 * CPB) return 1'b1;
        slot = off / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] wm, input logic rs);
        logic        busy_pre, pop, wr, st_rd, at_cap;
        logic [31:0] status;
        rst       = r;
        sel       = s;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wmask = wm;
        mem_rstrb = rs;
        @(posedge clk);
        cyc++;
        if (r) begin
            mq.delete();
            m_ovf   = 1'b0;
            fstart  = -1000;
            m_rdata = 32'h0;
        end else begin
            busy_pre = (cyc - 1 >= fstart) && (cyc - 1 - fstart < 10 * CPB);
            status   = {28'b0, m_ovf, mq.size() == 0, mq.size() == DEPTH, busy_pre};
            pop      = !busy_pre && (mq.size() > 0);
            wr       = s && !a[2] && wm[0];
            st_rd    = s && rs && a[2];
            at_cap   = (mq.size() == DEPTH) && !pop;
            if (s && rs) m_rdata = a[2] ? status : 32'h0;
            m_ovf = (m_ovf && !st_rd) || (wr && at_cap);
            if (pop) begin
                fbyte  = mq.pop_front();
                fstart = cyc;
            end
            if (wr && !at_cap) mq.push_back(wd[7:0]);
        end
        #1;
        check("tx", {31'b0, tx}, {31'b0, line_level(cyc - fstart, fbyte)});
        check("rdata", mem_rdata, m_rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic [3:0] wm);
        step(1'b0, 1'b1, 32'h0, {24'h0, d}, wm, 1'b0);
    endtask

    task automatic ld_status();
        step(1'b0, 1'b1, 32'h4, 32'h0, 4'h0, 1'b1);
    endtask

    initial begin
        logic [31:0]  ra, rwd;
        logic [3:0]   rwm;
        int unsigned  k;

        rst = 1'b1; sel = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;

        // Reset held for five edges, then a STATUS load.
        repeat (5) step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        ld_status();
        check("status_after_reset", mem_rdata, 32'h4);

        // Single byte 0x55 through a complete frame.
        wr_byte(8'h55, 4'h1);
        idle(45);
        ld_status();
        check("status_after_frame", mem_rdata, 32'h4);

        // Six back-to-back writes: the sixth overflows.
        for (int i = 1; i <= 6; i++) wr_byte(8'(i), 4'h1);
        ld_status();
        check("status_overflow", mem_rdata, 32'hB);
        ld_status();
        check("status_ovf_cleared", mem_rdata, 32'h3);
        idle(5 * 41 + 5);
        ld_status();
        check("status_drained", mem_rdata, 32'h4);

        // Byte-lane 0 not enabled: the write is ignored.
        wr_byte(8'hAA, 4'b0010);
        idle(3);
        ld_status();
        check("status_masked", mem_rdata, 32'h4);

        // Reset ten edges into a frame aborts it and discards the queued byte.
        wr_byte(8'h0F, 4'h1);
        wr_byte(8'hF0, 4'h1);
        idle(8);
        step(1'b1, 1'b1, 32'h0, 32'h33, 4'hF, 1'b1);
        idle(100);
        ld_status();
        check("status_after_abort", mem_rdata, 32'h4);

        // Randomized traffic: writes, loads, unselected strobes and rare resets.
        for (int i = 0; i < 1500; i++) begin
            k   = $urandom_range(0, 199);
            ra  = $urandom;
            rwd = $urandom;
            rwm = 4'($urandom);
            if (k < 2) begin
                step(1'b1, 1'b1, ra, rwd, rwm, 1'($urandom));
            end else if (k < 26) begin
                ra[2] = 1'b0;
                if (k < 20) rwm[0] = 1'b1;
                step(1'b0, 1'b1, ra, rwd, rwm, 1'b0);
            end else if (k < 40) begin
                step(1'b0, 1'b1, ra, rwd, rwm, 1'b1);
            end else if (k < 50) begin
                step(1'b0, 1'b0, ra, rwd, rwm, 1'($urandom));
            end else if (k < 53) begin
                for (int j = 0; j < 6; j++) wr_byte(8'($urandom), 4'h1);
            end else begin
                step(1'b0, 1'b0, ra, rwd, 4'h0, 1'b0);
            end
        end
        idle(10 * CPB * (DEPTH + 1) + 10);
        ld_status();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
